alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Issue stage directly upstream of the ALU. Accepts one decoded instruction at a time and reads rs1/rs2 from the register file over a req/ack handshake.
- Forms operand B from the rs2 data or the immediate, then drives the ALU operand/valid interface until the ALU reports completion.
- Retires no-op forms locally: rd=x0 with no memory destination, or no destination at all. Provides a watchdog timeout and a retire counter.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles from entering ISSUE to alu_done before abort; legal range 2..65535.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dec_valid  in  1  decoded instruction valid
- dec_ready  out  1  stage can accept an instruction
- dec_op_code  in  4  ALU op code (ALU_OP_CODE encoding)
- dec_rs1  in  5  source register A
- dec_rs2  in  5  source register B
- dec_rd  in  5  destination register
- dec_imm  in  32  immediate
- dec_use_imm  in  1  1: operand B = dec_imm
- dec_reg_dest  in  1  result goes to the register file
- dec_mem_dest  in  1  result goes to memory
- dec_mem_addr  in  32  memory destination address
- rf_rd_req  out  1  register file read request
- rf_rd_addr_a  out  5  read address A
- rf_rd_addr_b  out  5  read address B
- rf_rd_data_a  in  32  read data A, valid with rf_rd_ack
- rf_rd_data_b  in  32  read data B, valid with rf_rd_ack
- rf_rd_ack  in  1  read data valid
- op_code  out  4  to ALU
- input_A  out  32  to ALU
- input_B  out  32  to ALU
- reg_out  out  1  to ALU
- reg_addr  out  5  to ALU
- mem_out  out  1  to ALU
- mem_addr  out  32  to ALU
- inputs_valid  out  1  to ALU
- alu_input_ack  in  1  from ALU
- alu_done  in  1  from ALU, one-cycle pulse
- issue_timeout  out  1  one-cycle pulse on watchdog abort
- retired_count  out  CNT_W  instructions retired (completed plus locally retired), wraps

Behaviour:
- States: IDLE, RF_READ, ISSUE, WAIT_DONE. All outputs are registered except dec_ready, which is 1 exactly when state==IDLE.
- Reset values: state IDLE, rf_rd_req=0, inputs_valid=0, issue_timeout=0, retired_count=0, and all address/data/control outputs 0. A reset mid-operation aborts immediately: the next cycle shows the reset values, nothing is retired, and inputs_valid drops.
- IDLE, on dec_valid&dec_ready:
  - Latch all dec_* fields.
  - No-op retire: if !dec_reg_dest&!dec_mem_dest, or dec_reg_dest&!dec_mem_dest&dec_rd==0, increment retired_count next cycle and stay IDLE. No RF read, no ALU issue.
  - Otherwise go to RF_READ with rf_rd_req=1, rf_rd_addr_a=rs1, rf_rd_addr_b=rs2 from the next cycle.
- RF_READ:
  - Hold rf_rd_req and the addresses until rf_rd_ack is sampled high.
  - On ack: input_A<=rf_rd_data_a; input_B<=dec_use_imm ? dec_imm : rf_rd_data_b; drive op_code, reg_out=dec_reg_dest, reg_addr=dec_rd, mem_out=dec_mem_dest, mem_addr from latched fields; rf_rd_req<=0; inputs_valid<=1; clear watchdog; go to ISSUE.
  - An RF read occurs even when dec_use_imm=1; rf_rd_data_b is then ignored.
- ISSUE: inputs_valid and all operand outputs are held stable. On alu_input_ack, go to WAIT_DONE.
- WAIT_DONE: inputs_valid stays high, because the ALU deasserts its write-valid if inputs_valid drops.
- Completion: alu_done sampled high in ISSUE or WAIT_DONE (alu_done in the same cycle as alu_input_ack counts) causes inputs_valid<=0, retired_count+1, and a return to IDLE. The earliest new accept is the cycle after IDLE is re-entered.
- Watchdog:
  - The counter starts at 0 on entry to ISSUE and increments every cycle in ISSUE/WAIT_DONE.
  - When it equals TIMEOUT_CYCLES-1 with no alu_done that cycle: inputs_valid<=0, issue_timeout pulses for 1 cycle, go to IDLE, retired_count unchanged.
  - alu_done in that same cycle wins: normal completion, no timeout.
  - The watchdog does not run in RF_READ; an RF stall waits indefinitely.
- Stray inputs: alu_done or alu_input_ack outside ISSUE/WAIT_DONE, and rf_rd_ack outside RF_READ, are ignored.
- retired_count wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reg-file ADD: rs1=1 (data 5), rs2=2 (data 7), rd=3, reg_dest=1; rf ack 2 cycles later; ALU ack +1 cycle, done +3 cycles -> input_A=5, input_B=7, reg_addr=3, reg_out=1, mem_out=0; inputs_valid high continuously from the issue cycle through the done cycle, then 0; retired_count=1; dec_ready returns high.
- Immediate to memory: dec_use_imm=1, imm=0xFFFF_FFF0, mem_dest=1, mem_addr=0x100, rf_rd_data_b=0x1234 -> input_B=0xFFFF_FFF0, mem_out=1, mem_addr=0x100, reg_out=0.
- x0 discard: reg_dest=1, rd=0, mem_dest=0 -> rf_rd_req and inputs_valid never assert; retired_count+1 one cycle after accept.
- Timeout: TIMEOUT_CYCLES=4, ALU acks but never sends done -> inputs_valid low and issue_timeout pulses exactly 4 cycles after ISSUE entry; retired_count unchanged; the next instruction is accepted normally.
- Boundaries: alu_done in the same cycle as alu_input_ack -> completion, no WAIT_DONE dwell. alu_done in the watchdog expiry cycle -> no issue_timeout, retired_count increments.
- Reset in WAIT_DONE -> next cycle inputs_valid=0, state IDLE, retired_count=0. Counter at 0xFFFF with a completion -> wraps to 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ALU issue stage: accepts one decoded instruction, reads rs1/rs2 from the
// register file over a req/ack handshake, then presents registered operands
// to the ALU until it reports done. No-op forms (no destination, or rd=x0
// with no memory destination) retire locally without touching the RF or ALU.
// A watchdog aborts the issue if the ALU never completes.
module alu_issue_stage #(
    parameter int TIMEOUT_CYCLES = 64,   // legal range 2..65535
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,

    // decoded instruction
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [3:0]       dec_op_code,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic [4:0]       dec_rd,
    input  logic [31:0]      dec_imm,
    input  logic             dec_use_imm,
    input  logic             dec_reg_dest,
    input  logic             dec_mem_dest,
    input  logic [31:0]      dec_mem_addr,

    // register file read port
    output logic             rf_rd_req,
    output logic [4:0]       rf_rd_addr_a,
    output logic [4:0]       rf_rd_addr_b,
    input  logic [31:0]      rf_rd_data_a,
    input  logic [31:0]      rf_rd_data_b,
    input  logic             rf_rd_ack,

    // ALU interface
    output logic [3:0]       op_code,
    output logic [31:0]      input_A,
    output logic [31:0]      input_B,
    output logic             reg_out,
    output logic [4:0]       reg_addr,
    output logic             mem_out,
    output logic [31:0]      mem_addr,
    output logic             inputs_valid,
    input  logic             alu_input_ack,
    input  logic             alu_done,

    // status
    output logic             issue_timeout,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RF_READ   = 2'd1;
    localparam logic [1:0] ST_ISSUE     = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    // 16 bits covers the largest legal timeout; the count never passes
    // TIMEOUT_CYCLES-1 because reaching it ends the issue.
    localparam int              WD_W    = 16;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q,         state_d;

    // instruction fields captured at accept
    logic [3:0]       lat_op_q,        lat_op_d;
    logic [4:0]       lat_rd_q,        lat_rd_d;
    logic [31:0]      lat_imm_q,       lat_imm_d;
    logic             lat_use_imm_q,   lat_use_imm_d;
    logic             lat_reg_dest_q,  lat_reg_dest_d;
    logic             lat_mem_dest_q,  lat_mem_dest_d;
    logic [31:0]      lat_mem_addr_q,  lat_mem_addr_d;

    // registered outputs
    logic             rf_rd_req_q,     rf_rd_req_d;
    logic [4:0]       rf_addr_a_q,     rf_addr_a_d;
    logic [4:0]       rf_addr_b_q,     rf_addr_b_d;
    logic [3:0]       op_code_q,       op_code_d;
    logic [31:0]      input_a_q,       input_a_d;
    logic [31:0]      input_b_q,       input_b_d;
    logic             reg_out_q,       reg_out_d;
    logic [4:0]       reg_addr_q,      reg_addr_d;
    logic             mem_out_q,       mem_out_d;
    logic [31:0]      mem_addr_q,      mem_addr_d;
    logic             inputs_valid_q,  inputs_valid_d;
    logic             issue_timeout_q, issue_timeout_d;
    logic [CNT_W-1:0] retired_q,       retired_d;

    logic [WD_W-1:0]  wd_q,            wd_d;

    logic             dec_is_noop;

    // An instruction with nothing to write, or only a write to x0, has no
    // architectural effect and is retired without an RF read or ALU issue.
    assign dec_is_noop = !dec_mem_dest && (!dec_reg_dest || (dec_rd == 5'd0));

    // Next-state and output-register computation for the issue FSM.
    always_comb begin
        state_d         = state_q;
        lat_op_d        = lat_op_q;
        lat_rd_d        = lat_rd_q;
        lat_imm_d       = lat_imm_q;
        lat_use_imm_d   = lat_use_imm_q;
        lat_reg_dest_d  = lat_reg_dest_q;
        lat_mem_dest_d  = lat_mem_dest_q;
        lat_mem_addr_d  = lat_mem_addr_q;
        rf_rd_req_d     = rf_rd_req_q;
        rf_addr_a_d     = rf_addr_a_q;
        rf_addr_b_d     = rf_addr_b_q;
        op_code_d       = op_code_q;
        input_a_d       = input_a_q;
        input_b_d       = input_b_q;
        reg_out_d       = reg_out_q;
        reg_addr_d      = reg_addr_q;
        mem_out_d       = mem_out_q;
        mem_addr_d      = mem_addr_q;
        inputs_valid_d  = inputs_valid_q;
        issue_timeout_d = 1'b0;
        retired_d       = retired_q;
        wd_d            = wd_q;

        case (state_q)
            ST_IDLE: begin
                if (dec_valid) begin
                    lat_op_d       = dec_op_code;
                    lat_rd_d       = dec_rd;
                    lat_imm_d      = dec_imm;
                    lat_use_imm_d  = dec_use_imm;
                    lat_reg_dest_d = dec_reg_dest;
                    lat_mem_dest_d = dec_mem_dest;
                    lat_mem_addr_d = dec_mem_addr;
                    if (dec_is_noop) begin
                        retired_d = retired_q + CNT_W'(1);
                    end else begin
                        rf_rd_req_d = 1'b1;
                        rf_addr_a_d = dec_rs1;
                        rf_addr_b_d = dec_rs2;
                        state_d     = ST_RF_READ;
                    end
                end
            end

            ST_RF_READ: begin
                // No watchdog here: a stalled register file is waited on.
                if (rf_rd_ack) begin
                    input_a_d      = rf_rd_data_a;
                    // The RF read still happens for immediates; data B is dropped.
                    input_b_d      = lat_use_imm_q ? lat_imm_q : rf_rd_data_b;
                    op_code_d      = lat_op_q;
                    reg_out_d      = lat_reg_dest_q;
                    reg_addr_d     = lat_rd_q;
                    mem_out_d      = lat_mem_dest_q;
                    mem_addr_d     = lat_mem_addr_q;
                    rf_rd_req_d    = 1'b0;
                    inputs_valid_d = 1'b1;
                    wd_d           = '0;
                    state_d        = ST_ISSUE;
                end
            end

            ST_ISSUE, ST_WAIT_DONE: begin
                // inputs_valid stays up through WAIT_DONE: the ALU withdraws
                // its write-valid if it sees inputs_valid fall early.
                wd_d = wd_q + WD_W'(1);
                if (alu_done) begin
                    // Completion beats a watchdog expiry in the same cycle.
                    inputs_valid_d = 1'b0;
                    retired_d      = retired_q + CNT_W'(1);
                    state_d        = ST_IDLE;
                end else if (wd_q == WD_LAST) begin
                    inputs_valid_d  = 1'b0;
                    issue_timeout_d = 1'b1;
                    state_d         = ST_IDLE;
                end else if ((state_q == ST_ISSUE) && alu_input_ack) begin
                    state_d = ST_WAIT_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset returns every output to zero at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            lat_op_q        <= '0;
            lat_rd_q        <= '0;
            lat_imm_q       <= '0;
            lat_use_imm_q   <= 1'b0;
            lat_reg_dest_q  <= 1'b0;
            lat_mem_dest_q  <= 1'b0;
            lat_mem_addr_q  <= '0;
            rf_rd_req_q     <= 1'b0;
            rf_addr_a_q     <= '0;
            rf_addr_b_q     <= '0;
            op_code_q       <= '0;
            input_a_q       <= '0;
            input_b_q       <= '0;
            reg_out_q       <= 1'b0;
            reg_addr_q      <= '0;
            mem_out_q       <= 1'b0;
            mem_addr_q      <= '0;
            inputs_valid_q  <= 1'b0;
            issue_timeout_q <= 1'b0;
            retired_q       <= '0;
            wd_q            <= '0;
        end else begin
            state_q         <= state_d;
            lat_op_q        <= lat_op_d;
            lat_rd_q        <= lat_rd_d;
            lat_imm_q       <= lat_imm_d;
            lat_use_imm_q   <= lat_use_imm_d;
            lat_reg_dest_q  <= lat_reg_dest_d;
            lat_mem_dest_q  <= lat_mem_dest_d;
            lat_mem_addr_q  <= lat_mem_addr_d;
            rf_rd_req_q     <= rf_rd_req_d;
            rf_addr_a_q     <= rf_addr_a_d;
            rf_addr_b_q     <= rf_addr_b_d;
            op_code_q       <= op_code_d;
            input_a_q       <= input_a_d;
            input_b_q       <= input_b_d;
            reg_out_q       <= reg_out_d;
            reg_addr_q      <= reg_addr_d;
            mem_out_q       <= mem_out_d;
            mem_addr_q      <= mem_addr_d;
            inputs_valid_q  <= inputs_valid_d;
            issue_timeout_q <= issue_timeout_d;
            retired_q       <= retired_d;
            wd_q            <= wd_d;
        end
    end

    assign dec_ready     = (state_q == ST_IDLE);
    assign rf_rd_req     = rf_rd_req_q;
    assign rf_rd_addr_a  = rf_addr_a_q;
    assign rf_rd_addr_b  = rf_addr_b_q;
    assign op_code       = op_code_q;
    assign input_A       = input_a_q;
    assign input_B       = input_b_q;
    assign reg_out       = reg_out_q;
    assign reg_addr      = reg_addr_q;
    assign mem_out       = mem_out_q;
    assign mem_addr      = mem_addr_q;
    assign inputs_valid  = inputs_valid_q;
    assign issue_timeout = issue_timeout_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage. Expected ALU issue records are pushed to
// a scoreboard queue when an instruction is driven and popped when the DUT
// raises inputs_valid. A short watchdog and a narrow retire counter keep the
// timeout and wrap cases quick.
module tb_alu_issue_stage;

    localparam int TO = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          dec_valid;
    logic          dec_ready;
    logic [3:0]    dec_op_code;
    logic [4:0]    dec_rs1, dec_rs2, dec_rd;
    logic [31:0]   dec_imm;
    logic          dec_use_imm, dec_reg_dest, dec_mem_dest;
    logic [31:0]   dec_mem_addr;
    logic          rf_rd_req;
    logic [4:0]    rf_rd_addr_a, rf_rd_addr_b;
    logic [31:0]   rf_rd_data_a, rf_rd_data_b;
    logic          rf_rd_ack;
    logic [3:0]    op_code;
    logic [31:0]   input_A, input_B;
    logic          reg_out;
    logic [4:0]    reg_addr;
    logic          mem_out;
    logic [31:0]   mem_addr;
    logic          inputs_valid;
    logic          alu_input_ack, alu_done;
    logic          issue_timeout;
    logic [CW-1:0] retired_count;

    always #5 clk = ~clk;

    alu_issue_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op_code(dec_op_code),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_imm(dec_imm),
        .dec_use_imm(dec_use_imm), .dec_reg_dest(dec_reg_dest),
        .dec_mem_dest(dec_mem_dest), .dec_mem_addr(dec_mem_addr),
        .rf_rd_req(rf_rd_req), .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b), .rf_rd_ack(rf_rd_ack),
        .op_code(op_code), .input_A(input_A), .input_B(input_B),
        .reg_out(reg_out), .reg_addr(reg_addr), .mem_out(mem_out), .mem_addr(mem_addr),
        .inputs_valid(inputs_valid), .alu_input_ack(alu_input_ack), .alu_done(alu_done),
        .issue_timeout(issue_timeout), .retired_count(retired_count)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        reg_out;
        logic [4:0]  reg_addr;
        logic        mem_out;
        logic [31:0] mem_addr;
    } issue_t;

    issue_t        sb_q[$];
    int            n_pass  = 0;
    int            n_total = 0;
    logic [CW-1:0] exp_retired;
    logic [4:0]    cur_rs1, cur_rs2;
    logic [31:0]   cur_rfa, cur_rfb;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        dec_valid = 0; dec_op_code = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        dec_imm = 0; dec_use_imm = 0; dec_reg_dest = 0; dec_mem_dest = 0;
        dec_mem_addr = 0; rf_rd_data_a = 0; rf_rd_data_b = 0; rf_rd_ack = 0;
        alu_input_ack = 0; alu_done = 0;
    endtask

    // Drive one instruction (sampled at the next edge) and, unless it is a
    // local no-op, push the ALU issue record the DUT should later present.
    task automatic send(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] imm, input logic use_imm,
                        input logic rdest, input logic mdest, input logic [31:0] maddr,
                        input logic [31:0] rfa, input logic [31:0] rfb);
        issue_t e;
        dec_valid = 1; dec_op_code = op; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
        dec_imm = imm; dec_use_imm = use_imm; dec_reg_dest = rdest;
        dec_mem_dest = mdest; dec_mem_addr = maddr;
        cur_rs1 = rs1; cur_rs2 = rs2; cur_rfa = rfa; cur_rfb = rfb;
        if (mdest || (rdest && rd != 5'd0)) begin
            e.op = op; e.a = rfa; e.b = use_imm ? imm : rfb;
            e.reg_out = rdest; e.reg_addr = rd; e.mem_out = mdest; e.mem_addr = maddr;
            sb_q.push_back(e);
        end
    endtask

    // Accept, RF handshake after `stall` wait cycles, then compare the issue.
    task automatic run_to_issue(input int stall, input logic stray_done);
        issue_t e;
        tick();
        dec_valid = 0;
        check("rf_req_on", rf_rd_req, 1);
        check("rf_addr_a", rf_rd_addr_a, cur_rs1);
        check("rf_addr_b", rf_rd_addr_b, cur_rs2);
        check("busy_ready", dec_ready, 0);
        for (int i = 0; i < stall; i++) begin
            alu_done = stray_done;
            tick();
            check("rf_req_hold", rf_rd_req, 1);
            check("iv_during_rf", inputs_valid, 0);
        end
        alu_done = 0;
        rf_rd_ack = 1; rf_rd_data_a = cur_rfa; rf_rd_data_b = cur_rfb;
        tick();
        rf_rd_ack = 0; rf_rd_data_a = 32'hDEAD_0000; rf_rd_data_b = 32'hDEAD_0001;
        check("rf_req_off", rf_rd_req, 0);
        check("iv_issue", inputs_valid, 1);
        check("sb_nonempty", sb_q.size(), 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("op_code", op_code, e.op);
            check("input_A", input_A, e.a);
            check("input_B", input_B, e.b);
            check("reg_out", reg_out, e.reg_out);
            check("reg_addr", reg_addr, e.reg_addr);
            check("mem_out", mem_out, e.mem_out);
            check("mem_addr", mem_addr, e.mem_addr);
            $display("txn issue op=%0h A=%08h B=%08h reg=%0d/%0d mem=%0d/%08h",
                     op_code, input_A, input_B, reg_out, reg_addr, mem_out, mem_addr);
        end
    endtask

    // Drive a local no-op for one edge and confirm it retires without activity.
    task automatic noop_case(input string tag, input logic rdest, input logic [4:0] rd);
        send(4'h3, 5'd6, 5'd7, rd, 32'h0, 1'b0, rdest, 1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        dec_valid = 0;
        exp_retired++;
        check({tag, "_retired"}, retired_count, exp_retired);
        check({tag, "_rf_req"}, rf_rd_req, 0);
        check({tag, "_iv"}, inputs_valid, 0);
        check({tag, "_ready"}, dec_ready, 1);
        tick();
        check({tag, "_rf_req2"}, rf_rd_req, 0);
        check({tag, "_iv2"}, inputs_valid, 0);
        $display("txn %s retired count=%0d", tag, retired_count);
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        exp_retired = '0;
        check("rst_ready", dec_ready, 1);
        check("rst_rf_req", rf_rd_req, 0);
        check("rst_iv", inputs_valid, 0);
        check("rst_timeout", issue_timeout, 0);
        check("rst_retired", retired_count, 0);
        check("rst_input_A", input_A, 0);
        check("rst_mem_addr", mem_addr, 0);
        $display("txn reset done");

        // Register-file ADD, RF acks after two stall cycles, done two cycles after ack.
        send(4'h1, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'd5, 32'd7);
        run_to_issue(2, 1'b0);
        alu_input_ack = 1;
        tick();
        alu_input_ack = 0;
        check("add_iv_wait1", inputs_valid, 1);
        tick();
        check("add_iv_wait2", inputs_valid, 1);
        check("add_input_A_stable", input_A, 32'd5);
        alu_done = 1;
        tick();
        alu_done = 0;
        exp_retired++;
        check("add_iv_done", inputs_valid, 0);
        check("add_retired", retired_count, exp_retired);
        check("add_ready", dec_ready, 1);
        check("add_no_timeout", issue_timeout, 0);

        // Immediate to memory, stray alu_done during RF stall, ack+done same cycle.
        send(4'h2, 5'd4, 5'd5, 5'd0, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b1, 32'h100,
             32'h0000_A5A5, 32'h0000_1234);
        run_to_issue(1, 1'b1);
        alu_input_ack = 1; alu_done = 1;
        tick();
        alu_input_ack = 0; alu_done = 0;
        exp_retired++;
        check("imm_iv_done", inputs_valid, 0);
        check("imm_retired", retired_count, exp_retired);
        check("imm_ready", dec_ready, 1);

        noop_case("x0_discard", 1'b1, 5'd0);
        noop_case("no_dest", 1'b0, 5'd9);

        // Watchdog: ALU acks but never completes.
        send(4'h4, 5'd8, 5'd9, 5'd7, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h11, 32'h22);
        run_to_issue(0, 1'b0);
        alu_input_ack = 1;
        for (int i = 1; i < TO; i++) begin
            tick();
            alu_input_ack = 0;
            check("to_iv_hold", inputs_valid, 1);
            check("to_pulse_early", issue_timeout, 0);
        end
        tick();
        check("to_iv_drop", inputs_valid, 0);
        check("to_pulse", issue_timeout, 1);
        check("to_retired", retired_count, exp_retired);
        check("to_ready", dec_ready, 1);
        tick();
        check("to_pulse_end", issue_timeout, 0);
        $display("txn timeout observed");

        // alu_done exactly in the watchdog expiry cycle: completion wins.
        send(4'h5, 5'd10, 5'd11, 5'd12, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h33, 32'h44);
        run_to_issue(0, 1'b0);
        alu_input_ack = 1;
        for (int i = 1; i < TO; i++) begin
            tick();
            alu_input_ack = 0;
            check("exp_iv_hold", inputs_valid, 1);
        end
        alu_done = 1;
        tick();
        alu_done = 0;
        exp_retired++;
        check("exp_no_timeout", issue_timeout, 0);
        check("exp_iv_done", inputs_valid, 0);
        check("exp_retired", retired_count, exp_retired);

        // Stray handshakes while idle are ignored.
        alu_done = 1; alu_input_ack = 1; rf_rd_ack = 1;
        tick();
        alu_done = 0; alu_input_ack = 0; rf_rd_ack = 0;
        check("stray_retired", retired_count, exp_retired);
        check("stray_rf_req", rf_rd_req, 0);
        check("stray_iv", inputs_valid, 0);
        check("stray_ready", dec_ready, 1);
        $display("txn stray inputs ignored");

        // Fill the counter with back-to-back no-ops, then wrap it with a completion.
        while (exp_retired != {CW{1'b1}}) begin
            send(4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
            tick();
            exp_retired++;
        end
        dec_valid = 0;
        check("fill_max", retired_count, exp_retired);
        send(4'h6, 5'd13, 5'd14, 5'd15, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h55, 32'h66);
        run_to_issue(0, 1'b0);
        alu_input_ack = 1; alu_done = 1;
        tick();
        alu_input_ack = 0; alu_done = 0;
        exp_retired++;
        check("wrap_retired", retired_count, exp_retired);
        $display("txn counter wrap count=%0d", retired_count);

        // Reset while in WAIT_DONE.
        send(4'h7, 5'd16, 5'd17, 5'd18, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h77, 32'h88);
        run_to_issue(0, 1'b0);
        alu_input_ack = 1;
        tick();
        alu_input_ack = 0;
        check("rst2_iv_wait", inputs_valid, 1);
        reset = 1;
        tick();
        reset = 0;
        exp_retired = '0;
        check("rst2_iv", inputs_valid, 0);
        check("rst2_ready", dec_ready, 1);
        check("rst2_retired", retired_count, exp_retired);
        check("rst2_input_A", input_A, 0);
        check("rst2_reg_out", reg_out, 0);
        tick();
        check("rst2_ready_hold", dec_ready, 1);
        check("sb_drained", sb_q.size(), 0);
        $display("txn reset in WAIT_DONE");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
